// File: rtl/tx_serialiser.sv
// Byte-to-bit serialiser for the Tx path: takes bytes from the frame source and emits them
// LSB first to the bit encoder, with an optional odd parity bit after each full byte.
module tx_serialiser #(
  parameter bit PARITY_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_data_valid,
  input  logic [2:0] in_data_bits,
  output logic       in_req,
  output logic       out_data,
  output logic       out_data_valid,
  input  logic       out_req
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StData   = 2'd1;
  localparam logic [1:0] StParity = 2'd2;

  logic [1:0] state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [3:0] cnt_q, cnt_d;
  logic       full_q, full_d;
  logic       par_q, par_d;
  logic       out_data_q, out_data_d;
  logic       out_valid_q, out_valid_d;
  logic       in_req_q, in_req_d;

  logic       load;
  logic       end_of_byte;
  logic [3:0] load_cnt;

  // in_data_bits == 0 encodes a full 8-bit byte
  assign load_cnt = (in_data_bits == 3'd0) ? 4'd8 : {1'b0, in_data_bits};

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    full_d      = full_q;
    par_d       = par_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    in_req_d    = 1'b0;
    load        = 1'b0;
    end_of_byte = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (in_data_valid) begin
          load = 1'b1;
        end
      end
      StData: begin
        if (out_req) begin
          if (cnt_q > 4'd1) begin
            shift_d    = {1'b0, shift_q[7:1]};
            cnt_d      = cnt_q - 4'd1;
            par_d      = par_q ^ shift_q[0];
            out_data_d = shift_q[1];
          end else if (full_q && PARITY_EN) begin
            // par_q holds the XOR of the first seven bits; fold in the last one
            state_d    = StParity;
            cnt_d      = 4'd0;
            par_d      = par_q ^ shift_q[0];
            out_data_d = ~(par_q ^ shift_q[0]);
          end else begin
            end_of_byte = 1'b1;
          end
        end
      end
      StParity: begin
        if (out_req) begin
          end_of_byte = 1'b1;
        end
      end
      default: begin
        state_d     = StIdle;
        out_data_d  = 1'b0;
        out_valid_d = 1'b0;
      end
    endcase

    if (end_of_byte) begin
      if (in_data_valid) begin
        load = 1'b1;
      end else begin
        state_d     = StIdle;
        shift_d     = 8'd0;
        cnt_d       = 4'd0;
        full_d      = 1'b0;
        par_d       = 1'b0;
        out_data_d  = 1'b0;
        out_valid_d = 1'b0;
      end
    end

    if (load) begin
      state_d     = StData;
      shift_d     = in_data;
      cnt_d       = load_cnt;
      full_d      = (in_data_bits == 3'd0);
      par_d       = 1'b0;
      out_data_d  = in_data[0];
      out_valid_d = 1'b1;
      in_req_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      shift_q     <= 8'd0;
      cnt_q       <= 4'd0;
      full_q      <= 1'b0;
      par_q       <= 1'b0;
      out_data_q  <= 1'b0;
      out_valid_q <= 1'b0;
      in_req_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      full_q      <= full_d;
      par_q       <= par_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      in_req_q    <= in_req_d;
    end
  end

  assign in_req         = in_req_q;
  assign out_data       = out_data_q;
  assign out_data_valid = out_valid_q;

`ifndef SYNTHESIS
  a_in_req_single : assert property (@(posedge clk) disable iff (!rst_n)
    in_req_q |=> !in_req_q);

  // Bit interface: output only moves on the edge after out_req while a bit is pending
  a_out_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid_q && !out_req) |=> ($stable(out_data_q) && $stable(out_valid_q)));

  a_idle_quiet : assert property (@(posedge clk) disable iff (!rst_n)
    (!out_valid_q && !in_data_valid) |=> (!out_valid_q && !out_data_q));

  a_idle_data_zero : assert property (@(posedge clk) disable iff (!rst_n)
    !out_valid_q |-> !out_data_q);
`endif

endmodule
